moore_scheduler: RTL

MOORE_SCHEDULER -- requirements
Module: moore_scheduler

---
 rtl/moore_scheduler_pkg.sv | 21 ++
 rtl/moore_scheduler_if.sv | 29 ++
 rtl/moore_scheduler_rr_arbiter.sv | 27 ++
 rtl/moore_scheduler.sv | 128 ++++++++++++
 4 files changed

// File: rtl/moore_scheduler_pkg.sv
// Shared state encoding, default sizing and small helpers for the Moore
// compute-unit scheduler.
package moore_scheduler_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 64;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Index width that stays legal when the range has a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/moore_scheduler_if.sv
// Requester and compute-unit signals of the scheduler; the slave side is the
// scheduler, the master side is the requesters plus the compute unit.
interface moore_scheduler_if import moore_scheduler_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int W     = DEF_W
);

  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       rsp_data;
  logic               rsp_err;
  logic               busy;
  logic               u_start;
  logic [W-1:0]       u_data;
  logic [W-1:0]       u_out;
  logic               u_done;

  modport master (
    output req, req_data, u_out, u_done,
    input  ack, rsp_data, rsp_err, busy, u_start, u_data
  );

  modport slave (
    input  req, req_data, u_out, u_done,
    output ack, rsp_data, rsp_err, busy, u_start, u_data
  );

endinterface

// File: rtl/moore_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first active request after i_last,
// wrapping modulo N_REQ.
module moore_scheduler_rr_arbiter import moore_scheduler_pkg::*; #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic             o_valid,
  output logic [IW-1:0]    o_idx
);

  logic [IW-1:0] w_cand;

  // Scan farthest-to-nearest so the nearest requester after i_last overrides.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand  = IW'((int'(i_last) + k) % N_REQ);
      o_valid = o_valid | i_req[w_cand];
      o_idx   = i_req[w_cand] ? w_cand : o_idx;
    end
  end

endmodule

// File: rtl/moore_scheduler.sv
// Shares one external Moore compute unit among N_REQ requesters:
// IDLE -> START -> WAIT -> RESP -> IDLE, with a WAIT timeout that aborts.
module moore_scheduler import moore_scheduler_pkg::*; #(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  moore_scheduler_if.slave bus
);

  localparam int            IW       = idx_width(N_REQ);
  localparam int            CW       = idx_width(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IW-1:0]    r_grant;
  logic [IW-1:0]    r_last_grant;
  logic [CW-1:0]    r_wait_cnt;
  logic [W-1:0]     r_rsp_data;
  logic             r_rsp_err;
  logic [W-1:0]     r_u_data;

  logic             w_arb_valid;
  logic [IW-1:0]    w_arb_idx;
  logic             w_timeout;
  logic [N_REQ-1:0] w_ack;
  logic             w_u_start;
  logic             w_busy;
  logic [W-1:0]     w_ops [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_ops
    assign w_ops[g] = bus.req_data[g*W +: W];
  end

  moore_scheduler_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) rr_arbiter (
    .i_req   (bus.req),
    .i_last  (r_last_grant),
    .o_valid (w_arb_valid),
    .o_idx   (w_arb_idx)
  );

  // The count holds (WAIT cycles already spent); the current cycle is the last allowed one.
  assign w_timeout = (r_wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; u_done only matters in WAIT and beats the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_arb_valid ? START : IDLE;
      START:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = (bus.u_done || w_timeout) ? RESP : WAIT;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    w_ack     = '0;
    w_u_start = 1'b0;
    w_busy    = 1'b1;
    case (r_state)
      IDLE:    w_busy = 1'b0;
      START:   w_u_start = 1'b1;
      WAIT:    w_busy = 1'b1;
      RESP:    w_ack[r_grant] = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Grant/operand capture, WAIT counting, result capture and priority update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_grant      <= '0;
      r_last_grant <= IW'(N_REQ - 1);
      r_wait_cnt   <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_u_data     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_grant  <= w_arb_idx;
            r_u_data <= w_ops[w_arb_idx];
          end
        end
        START: r_wait_cnt <= '0;
        WAIT: begin
          if (bus.u_done) begin
            r_rsp_data <= bus.u_out;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        RESP:    r_last_grant <= r_grant;
        default: r_wait_cnt <= '0;
      endcase
    end
  end

  assign bus.ack      = w_ack;
  assign bus.u_start  = w_u_start;
  assign bus.busy     = w_busy;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_err  = r_rsp_err;
  assign bus.u_data   = r_u_data;

endmodule
